// File: rtl/bcd_scan_counter_pkg.sv
// Shared BCD types, constants and helpers for the BCD scan counter.
package bcd_scan_pkg;

   typedef logic [3:0] bcd_t;

   localparam bcd_t BCD_MAX   = 4'd9;
   localparam bcd_t BCD_BLANK = 4'hF;

   // Saturate a nibble into the legal BCD range.
   function automatic bcd_t bcd_clamp(input bcd_t d);
      return (d > BCD_MAX) ? BCD_MAX : d;
   endfunction

endpackage

// File: rtl/bcd_scan_counter_digit_cell.sv
// One BCD digit step: increments or decrements when i_cin is set, rippling carry/borrow out.
module bcd_digit_cell
   import bcd_scan_pkg::*;
(
   input  bcd_t i_digit,
   input  logic i_up,
   input  logic i_cin,
   output bcd_t o_digit_c,
   output logic o_cout_c
);

   always_comb begin
      o_digit_c = i_digit;
      o_cout_c  = 1'b0;
      if (i_cin) begin
         if (i_up) begin
            if (i_digit >= BCD_MAX) begin
               o_digit_c = 4'd0;
               o_cout_c  = 1'b1;
            end else begin
               o_digit_c = i_digit + 4'd1;
            end
         end else begin
            if (i_digit == 4'd0) begin
               o_digit_c = BCD_MAX;
               o_cout_c  = 1'b1;
            end else begin
               o_digit_c = i_digit - 4'd1;
            end
         end
      end
   end

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with time-multiplexed digit scan output.
// Optional leading-zero blanking when BCD_SCAN_LEADING_ZERO_BLANK_EN is defined.
module bcd_scan_counter
   import bcd_scan_pkg::*;
#(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned TICK_DIV = 50000000,
   parameter int unsigned SCAN_DIV = 50000
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                up,
   input  logic                clr,
   input  logic                load,
   input  logic [4*DIGITS-1:0] load_val,
   output logic [4*DIGITS-1:0] count,
   output logic                carry,
   output logic [3:0]          bcd,
   output logic [DIGITS-1:0]   dig_sel
);

   localparam int unsigned CW = 4 * DIGITS;
   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IW = $clog2(DIGITS);
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
   localparam bit LZB_EN = 1'b1;
`else
   localparam bit LZB_EN = 1'b0;
`endif

   logic [PW-1:0]     r_presc;
   logic [SW-1:0]     r_scan;
   logic [IW-1:0]     r_idx;
   logic [CW-1:0]     r_count;
   logic              r_carry;
   bcd_t              r_bcd;
   logic [DIGITS-1:0] r_dig_sel;

   logic              w_tick;
   logic              w_wrap;
   logic [CW-1:0]     w_count_step;
   logic [CW-1:0]     w_load_clamped;
   bcd_t              w_dig [DIGITS];
   bcd_t              w_scan_bcd;

   assign w_tick = en && (r_presc == PW'(TICK_DIV - 1));

   // Ripple chain; each stage owns its carry wires so the chain stays acyclic per signal.
   for (genvar g = 0; g < DIGITS; g++) begin : g_cell
      logic w_ci;
      logic w_co;
      if (g == 0) begin : g_first
         assign w_ci = w_tick;
      end else begin : g_next
         assign w_ci = g_cell[g-1].w_co;
      end
      bcd_digit_cell u_cell (
         .i_digit   (r_count[4*g +: 4]),
         .i_up      (up),
         .i_cin     (w_ci),
         .o_digit_c (w_count_step[4*g +: 4]),
         .o_cout_c  (w_co)
      );
      assign w_load_clamped[4*g +: 4] = bcd_clamp(load_val[4*g +: 4]);
      assign w_dig[g]                 = r_count[4*g +: 4];
   end

   assign w_wrap = g_cell[DIGITS-1].w_co;

   // Count, carry and prescaler; clr beats load beats tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
         r_carry <= 1'b0;
         r_presc <= '0;
      end else if (clr) begin
         r_count <= '0;
         r_carry <= 1'b0;
         r_presc <= '0;
      end else if (load) begin
         r_count <= w_load_clamped;
         r_carry <= 1'b0;
         r_presc <= '0;
      end else begin
         r_count <= w_count_step;
         r_carry <= w_wrap;
         if (en) begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
         end
      end
   end

   // Scanned digit code, with higher-order zero digits blanked when enabled.
   always_comb begin
      logic v_zero;
      w_scan_bcd = w_dig[r_idx];
      v_zero     = 1'b1;
      if (LZB_EN) begin
         for (int i = DIGITS - 1; i >= 1; i--) begin
            v_zero = v_zero && (w_dig[i] == 4'd0);
            if (v_zero && (r_idx == IW'(i))) begin
               w_scan_bcd = BCD_BLANK;
            end
         end
      end
   end

   // Free-running scanner; digit code and select are registered together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scan    <= '0;
         r_idx     <= '0;
         r_bcd     <= BCD_BLANK;
         r_dig_sel <= '1;
      end else begin
         if (r_scan == SW'(SCAN_DIV - 1)) begin
            r_scan <= '0;
            r_idx  <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
         end else begin
            r_scan <= r_scan + SW'(1);
         end
         r_bcd     <= w_scan_bcd;
         r_dig_sel <= ~(DIGITS'(1) << r_idx);
      end
   end

   assign count   = r_count;
   assign carry   = r_carry;
   assign bcd     = r_bcd;
   assign dig_sel = r_dig_sel;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Self-checking bench for bcd_scan_counter (DIGITS=4, TICK_DIV=4, SCAN_DIV=2) against an integer model.
module tb_bcd_scan_counter;

   localparam int TICK_DIV = 4;
   localparam int SCAN_DIV = 2;
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n, en, up, clr, load;
   logic [15:0] load_val;
   logic [15:0] count;
   logic        carry;
   logic [3:0]  bcd;
   logic [3:0]  dig_sel;

   int total = 0;
   int bad   = 0;

   // Model state: count as a plain decimal integer.
   int         m_count, m_presc, m_scan, m_idx;
   logic       m_carry;
   logic [3:0] m_bcd, m_sel;

   bcd_scan_counter #(.DIGITS(4), .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
      .load_val(load_val), .count(count), .carry(carry), .bcd(bcd), .dig_sel(dig_sel)
   );

   always #5 clk = ~clk;

   function automatic int pow10(input int i);
      int r = 1;
      for (int k = 0; k < i; k++) r = r * 10;
      return r;
   endfunction

   function automatic logic [15:0] to_bcd(input int n);
      logic [15:0] r;
      for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'((n / pow10(i)) % 10);
      return r;
   endfunction

   function automatic int from_load(input logic [15:0] v);
      int n = 0;
      int d;
      for (int i = 0; i < 4; i++) begin
         d = int'(v[4*i +: 4]);
         if (d > 9) d = 9;
         n = n + d * pow10(i);
      end
      return n;
   endfunction

   task automatic model_reset();
      m_count = 0; m_presc = 0; m_scan = 0; m_idx = 0;
      m_carry = 1'b0; m_bcd = 4'hF; m_sel = 4'hF;
   endtask

   task automatic model_step();
      bit tick;
      tick  = en && (m_presc == TICK_DIV - 1);
      m_bcd = (LZB && m_idx > 0 && m_count < pow10(m_idx)) ? 4'hF
                                                            : 4'((m_count / pow10(m_idx)) % 10);
      m_sel = ~(4'b0001 << m_idx);
      if (clr) begin
         m_count = 0; m_presc = 0; m_carry = 1'b0;
      end else if (load) begin
         m_count = from_load(load_val); m_presc = 0; m_carry = 1'b0;
      end else begin
         m_carry = 1'b0;
         if (tick) begin
            if (up) begin
               if (m_count == 9999) begin m_count = 0; m_carry = 1'b1; end
               else m_count = m_count + 1;
            end else begin
               if (m_count == 0) begin m_count = 9999; m_carry = 1'b1; end
               else m_count = m_count - 1;
            end
         end
         if (en) m_presc = tick ? 0 : m_presc + 1;
      end
      if (m_scan == SCAN_DIV - 1) begin
         m_scan = 0;
         m_idx  = (m_idx + 1) % 4;
      end else begin
         m_scan = m_scan + 1;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;
      #12;
      model_reset();
      total++; if (count !== 16'h0000) begin bad++; $display("FAIL reset_count got=%h want=0000", count); end
      total++; if (carry !== 1'b0) begin bad++; $display("FAIL reset_carry got=%b want=0", carry); end
      total++; if (bcd !== 4'hF) begin bad++; $display("FAIL reset_bcd got=%h want=f", bcd); end
      total++; if (dig_sel !== 4'b1111) begin bad++; $display("FAIL reset_dig_sel got=%b want=1111", dig_sel); end
      en = 1'b1; up = 1'b1;
      rst_n = 1'b1;
   endtask

   task automatic test_count_up();
      logic [3:0] sel_exp [8];
      sel_exp = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111, 4'b0111};
      for (int c = 1; c <= 9; c++) begin
         cycle();
         if (c <= 8) begin
            total++;
            if (dig_sel !== sel_exp[c-1]) begin
               bad++; $display("FAIL up_dig_sel c=%0d got=%b want=%b", c, dig_sel, sel_exp[c-1]);
            end
         end
         if (c == 3 || c == 4 || c == 8) begin
            total++;
            if (count !== to_bcd(c / 4)) begin
               bad++; $display("FAIL up_count c=%0d got=%h want=%h", c, count, to_bcd(c / 4));
            end
         end
      end
      total++; if (dig_sel !== 4'b1110) begin bad++; $display("FAIL up_dig_sel_wrap got=%b want=1110", dig_sel); end
   endtask

   task automatic test_wrap(input logic [15:0] start, input logic dir, input logic [15:0] mid,
                            input logic [15:0] fin, input string name);
      int pulses = 0;
      en = 1'b1; up = dir; load = 1'b1; load_val = start;
      cycle();
      load = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         cycle();
         if (carry === 1'b1) pulses++;
         total++;
         if (carry !== m_carry) begin bad++; $display("FAIL %s_carry c=%0d got=%b want=%b", name, c, carry, m_carry); end
         if (c == 4) begin
            total++; if (count !== mid) begin bad++; $display("FAIL %s_mid got=%h want=%h", name, count, mid); end
         end
         if (c == 8) begin
            total++; if (count !== fin) begin bad++; $display("FAIL %s_final got=%h want=%h", name, count, fin); end
         end
      end
      total++;
      if (pulses != 1) begin bad++; $display("FAIL %s_pulses got=%0d want=1", name, pulses); end
   endtask

   task automatic test_clamp();
      load = 1'b1; load_val = 16'hA3F5;
      cycle();
      total++; if (count !== 16'h9395) begin bad++; $display("FAIL clamp got=%h want=9395", count); end
      clr = 1'b1;
      cycle();
      clr = 1'b0; load = 1'b0;
      total++; if (count !== 16'h0000) begin bad++; $display("FAIL clr_over_load got=%h want=0000", count); end
      total++; if (carry !== 1'b0) begin bad++; $display("FAIL clr_carry got=%b want=0", carry); end
   endtask

   task automatic test_hold();
      logic [3:0] seen = '0;
      en = 1'b1; up = 1'b1; load = 1'b1; load_val = 16'h1234;
      cycle();
      load = 1'b0;
      cycle(); cycle();
      en = 1'b0;
      for (int c = 0; c < 20; c++) begin
         cycle();
         seen = seen | ~dig_sel;
         total++; if (count !== 16'h1234) begin bad++; $display("FAIL hold_count c=%0d got=%h want=1234", c, count); end
      end
      total++; if (seen !== 4'b1111) begin bad++; $display("FAIL hold_scan got=%b want=1111", seen); end
      en = 1'b1;
      for (int c = 0; c < 6; c++) begin
         cycle();
         total++;
         if (count !== to_bcd(m_count)) begin bad++; $display("FAIL resume_count c=%0d got=%h want=%h", c, count, to_bcd(m_count)); end
      end
   endtask

   task automatic test_blank();
      logic [3:0] exp_b [4];
      int idx;
      exp_b = LZB ? '{4'h0, 4'h4, 4'hF, 4'hF} : '{4'h0, 4'h4, 4'h0, 4'h0};
      en = 1'b0; load = 1'b1; load_val = 16'h0040;
      cycle();
      load = 1'b0;
      cycle();
      for (int c = 0; c < 8; c++) begin
         cycle();
         case (dig_sel)
            4'b1110: idx = 0;
            4'b1101: idx = 1;
            4'b1011: idx = 2;
            4'b0111: idx = 3;
            default: idx = -1;
         endcase
         total++;
         if (idx < 0) begin bad++; $display("FAIL blank_sel got=%b want=one-hot-low", dig_sel); end
         else if (bcd !== exp_b[idx]) begin bad++; $display("FAIL blank_bcd d=%0d got=%h want=%h", idx, bcd, exp_b[idx]); end
      end
   endtask

   task automatic test_random();
      int pick;
      for (int c = 0; c < 600; c++) begin
         en   = ($urandom_range(0, 3) != 0);
         up   = 1'($urandom_range(0, 1));
         clr  = ($urandom_range(0, 39) == 0);
         load = ($urandom_range(0, 14) == 0);
         pick = $urandom_range(0, 4);
         case (pick)
            0: load_val = 16'h9999;
            1: load_val = 16'h0000;
            2: load_val = 16'h0009;
            default: load_val = 16'($urandom);
         endcase
         cycle();
         total++;
         if (count !== to_bcd(m_count) || carry !== m_carry || bcd !== m_bcd || dig_sel !== m_sel) begin
            bad++;
            $display("FAIL random c=%0d got=%h/%b/%h/%b want=%h/%b/%h/%b", c, count, carry, bcd, dig_sel,
                     to_bcd(m_count), m_carry, m_bcd, m_sel);
         end
      end
      clr = 1'b0; load = 1'b0;
   endtask

   task automatic test_async_reset();
      en = 1'b1; up = 1'b1; load = 1'b1; load_val = 16'h0567;
      cycle();
      load = 1'b0;
      cycle();
      #1;
      rst_n = 1'b0;
      #1;
      total++; if (dig_sel !== 4'b1111) begin bad++; $display("FAIL async_dig_sel got=%b want=1111", dig_sel); end
      total++; if (bcd !== 4'hF) begin bad++; $display("FAIL async_bcd got=%h want=f", bcd); end
      total++; if (count !== 16'h0000) begin bad++; $display("FAIL async_count got=%h want=0000", count); end
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_wrap(16'h9998, 1'b1, 16'h9999, 16'h0000, "wrap_up");
      test_wrap(16'h0001, 1'b0, 16'h0000, 16'h9999, "wrap_down");
      test_clamp();
      test_hold();
      test_blank();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
